// File: rtl/display_scan_mux.sv
// Four-digit multiplexed display scanner: shows each BCD digit for SCAN_DIV cycles, latching new frames only at scan boundaries.
// Latency: load reaches pending 1 cycle later and active at the next frame boundary; outputs follow registered state with no comb path from din/load.
// Backpressure: none; load is always accepted, and a newer load overwrites an untransferred pending value.
//
// Ports:
//   clk, rst_n      - single rising-edge clock, asynchronous active-low reset
//   din, load       - four packed BCD digits ([3:0] = digit 0) and their capture strobe
//   bcd             - raw nibble of the digit currently scanned
//   dig_en          - one-hot digit select, all-zero while the slot is blanked
//   blank           - current slot is dark (non-decimal nibble, or leading zero)
//   frame_done      - one-cycle pulse after each completed 4-digit scan
// Optional build macro: LEADING_ZERO_BLANK_EN also blanks leading-zero digits 3..1.
module display_scan_mux #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        load,
  output logic [3:0]  bcd,
  output logic [3:0]  dig_en,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pending_q, pending_d;
  logic          pending_vld_q, pending_vld_d;
  logic [15:0]   active_q, active_d;
  logic          frame_done_q, frame_done_d;

  logic tc;
  logic boundary;

  always_comb begin
    tc       = (presc_q == PRESC_TC);
    boundary = tc && (idx_q == 2'd3);

    presc_d      = tc ? '0 : presc_q + 1'b1;
    idx_d        = tc ? idx_q + 2'd1 : idx_q;
    frame_done_d = boundary;

    // Active only moves at the frame boundary so a frame never mixes two values.
    active_d      = active_q;
    pending_vld_d = pending_vld_q;
    if (boundary && pending_vld_q) begin
      active_d      = pending_q;
      pending_vld_d = 1'b0;
    end

    // A load on the boundary edge still lands in pending after the old value moved on.
    pending_d = pending_q;
    if (load) begin
      pending_d     = din;
      pending_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= 2'd0;
      pending_q     <= 16'h0000;
      pending_vld_q <= 1'b0;
      active_q      <= 16'h0000;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      active_q      <= active_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Output decode works purely from flops, so din/load never reach the pins combinationally.
  logic [3:0] nib;
  logic       lead_zero;

  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    case (idx_q)
      2'd0: nib = active_q[3:0];
      2'd1: nib = active_q[7:4];
      2'd2: nib = active_q[11:8];
      default: nib = active_q[15:12];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are zero; digit 0 always shows.
    case (idx_q)
      2'd1: lead_zero = (active_q[15:4] == 12'h000);
      2'd2: lead_zero = (active_q[15:8] == 8'h00);
      2'd3: lead_zero = (active_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
`else
    lead_zero = 1'b0;
`endif
  end

  assign bcd        = nib;
  assign blank      = (nib > 4'd9) || lead_zero;
  assign dig_en     = blank ? 4'b0000 : (4'b0001 << idx_q);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

  localparam int D = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  dig_en;
  logic        blank;
  logic        frame_done;

  display_scan_mux #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
    .bcd(bcd), .dig_en(dig_en), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time measured as clock edges since reset, values as whole words.
  int          m_cyc;
  logic [15:0] m_pend, m_act;
  bit          m_pv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_out();
    int         idx;
    logic [3:0] nib;
    bit         lz, blk;
    logic [3:0] en;
    bit         fd;
    idx = (m_cyc / D) % 4;
    nib = 4'((m_act >> (4 * idx)) & 16'h000F);
    lz  = LZ && (idx > 0) && ((m_act >> (4 * idx)) == 0);
    blk = (nib > 9) || lz;
    en  = blk ? 4'b0000 : 4'(1 << idx);
    fd  = (m_cyc > 0) && (m_cyc % (4 * D) == 0);
    return {nib, en, blk, fd};
  endfunction

  task automatic model_step(input logic ld, input logic [15:0] d);
    bit bnd;
    bnd = ((m_cyc + 1) % (4 * D)) == 0;
    if (bnd && m_pv) begin
      m_act = m_pend;
      m_pv  = 0;
    end
    if (ld) begin
      m_pend = d;
      m_pv   = 1;
    end
    m_cyc++;
  endtask

  task automatic tick(input logic ld, input logic [15:0] d);
    load = ld;
    din  = d;
    @(posedge clk);
    model_step(ld, d);
    #1;
    load = 1'b0;
    chk("model", {22'd0, bcd, dig_en, blank, frame_done}, {22'd0, model_out()});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_cyc = 0; m_pend = 0; m_act = 0; m_pv = 0;
    chk("reset_outputs", {22'd0, bcd, dig_en, blank, frame_done}, {22'd0, 4'h0, 4'b0001, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] d;
    int          slot;
    logic [3:0]  e_bcd;
    logic [3:0]  e_en;
    logic        e_blank;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int fd_count, first_fd;
    bit seen9;
    logic [15:0] r;

    tbl[0]  = '{16'h1234, 0, 4'h4, 4'b0001, 1'b0};
    tbl[1]  = '{16'h1234, 3, 4'h1, 4'b1000, 1'b0};
    tbl[2]  = '{16'h00A9, 0, 4'h9, 4'b0001, 1'b0};
    tbl[3]  = '{16'h00A9, 1, 4'hA, 4'b0000, 1'b1};
    tbl[4]  = '{16'h00A9, 2, 4'h0, LZ ? 4'b0000 : 4'b0100, LZ};
    tbl[5]  = '{16'h0050, 3, 4'h0, LZ ? 4'b0000 : 4'b1000, LZ};
    tbl[6]  = '{16'h0050, 2, 4'h0, LZ ? 4'b0000 : 4'b0100, LZ};
    tbl[7]  = '{16'h0050, 1, 4'h5, 4'b0010, 1'b0};
    tbl[8]  = '{16'h0050, 0, 4'h0, 4'b0001, 1'b0};
    tbl[9]  = '{16'h0000, 0, 4'h0, 4'b0001, 1'b0};
    tbl[10] = '{16'h0000, 1, 4'h0, LZ ? 4'b0000 : 4'b0010, LZ};
    tbl[11] = '{16'hFFFF, 2, 4'hF, 4'b0000, 1'b1};

    // Reset behaviour, index step and frame_done cadence.
    do_reset();
    fd_count = 0;
    first_fd = 0;
    for (int i = 1; i <= 48; i++) begin
      tick(1'b0, 16'h0);
      if (i == D) chk("idx_step", {28'd0, dig_en}, {28'd0, LZ ? 4'b0000 : 4'b0010});
      if (frame_done) begin
        fd_count++;
        if (first_fd == 0) first_fd = i;
      end
    end
    chk("fd_count", fd_count, 3);
    chk("fd_first", first_fd, 16);

    // Table of per-slot displays after one loaded frame.
    for (int t = 0; t < 12; t++) begin
      do_reset();
      tick(1'b1, tbl[t].d);
      repeat (15) tick(1'b0, 16'h0);
      repeat (tbl[t].slot * D) tick(1'b0, 16'h0);
      chk($sformatf("tbl%0d", t), {23'd0, bcd, dig_en, blank},
          {23'd0, tbl[t].e_bcd, tbl[t].e_en, tbl[t].e_blank});
    end

    // Load mid-frame, then a second load on the boundary edge.
    do_reset();
    repeat (4) tick(1'b0, 16'h0);
    tick(1'b1, 16'h1234);
    repeat (3) tick(1'b0, 16'h0);
    chk("no_tear", {28'd0, bcd}, 32'h0);
    repeat (7) tick(1'b0, 16'h0);
    tick(1'b1, 16'h5678);
    chk("bnd_first", {27'd0, bcd, frame_done}, {27'd0, 4'h4, 1'b1});
    repeat (4) tick(1'b0, 16'h0);
    chk("bnd_slot1", {24'd0, bcd, dig_en}, {24'd0, 4'h3, 4'b0010});
    repeat (12) tick(1'b0, 16'h0);
    chk("bnd_second", {27'd0, bcd, frame_done}, {27'd0, 4'h8, 1'b1});
    repeat (12) tick(1'b0, 16'h0);
    chk("bnd_second_d3", {24'd0, bcd, dig_en}, {24'd0, 4'h5, 4'b1000});

    // Reset mid-frame discards the pending load.
    do_reset();
    tick(1'b1, 16'h9999);
    repeat (7) tick(1'b0, 16'h0);
    chk("mid_idx2", {28'd0, dig_en}, {28'd0, LZ ? 4'b0000 : 4'b0100});
    do_reset();
    seen9 = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 16'h0);
      if (bcd == 4'h9) seen9 = 1;
    end
    chk("9999_never", {31'd0, seen9}, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          r = 16'($urandom);
        end else begin
          r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          if ($urandom_range(0, 1) == 0) r[15:8] = 8'h00;
        end
        tick($urandom_range(0, 7) == 0, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit is shown (legal 2..65535).
REQ-002 SHALL have port clk, input, 1, single clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port din, input, 16, four packed BCD digits; [3:0] = digit 0 (least significant), [15:12] = digit 3.
REQ-005 SHALL have port load, input, 1, capture strobe for din.
REQ-006 SHALL have port bcd, output, 4, current digit nibble for the downstream BCD-to-7-segment decoder.
REQ-007 SHALL have port dig_en, output, 4, one-hot active-high digit select; bit n selects digit n.
REQ-008 SHALL have port blank, output, 1, high when the current digit is not to be lit.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse at each completed 4-digit scan.

Function
REQ-010 SHALL register din into a pending register on each rising clk edge where load=1; pending visible one cycle after load.
REQ-011 SHALL keep a separate pending_valid flag, set by load and cleared when pending is transferred to active.
REQ-012 SHALL display only from an active register; active SHALL change only at a frame boundary (no tearing).
REQ-013 SHALL run a prescaler counting 0..SCAN_DIV-1 continuously, wrapping to 0 at terminal count (TC).
REQ-014 SHALL advance a 2-bit digit index 0->1->2->3->0 on each TC; index otherwise holds.
REQ-015 SHALL drive dig_en = one-hot(index) and bcd = active[4*index+3 : 4*index], both from registered state (no combinational path from din/load).
REQ-016 SHALL define frame boundary as TC while index=3; on that edge: index->0, frame_done=1 for exactly the following cycle, and active<=pending if pending_valid.
REQ-017 SHALL, when load=1 on the frame-boundary edge, transfer the old pending to active and store new din in pending with pending_valid remaining set.
REQ-018 SHALL drive blank=1 when the current nibble exceeds 9 (4'hA..4'hF) and force dig_en to 4'b0000 for that digit slot; bcd still carries the raw nibble.
REQ-019 SHALL hold every digit for exactly SCAN_DIV cycles; full frame = 4*SCAN_DIV cycles.

Reset
REQ-020 SHALL, on rst_n=0 (asynchronous assert), clear prescaler, index=0, pending=0, pending_valid=0, active=0, frame_done=0.
REQ-021 SHALL present after reset: bcd=4'h0, dig_en=4'b0001, blank=0, frame_done=0.
REQ-022 SHALL release reset synchronously to clk; first TC occurs SCAN_DIV cycles after the first active edge.
REQ-023 SHALL discard any load pending when reset asserts mid-frame.

Configuration
REQ-024 SHALL honour macro LEADING_ZERO_BLANK_EN.
REQ-025 SHALL, with LEADING_ZERO_BLANK_EN defined, set blank=1 and dig_en=4'b0000 for digit n (n=1..3) when active digit n and all more-significant digits are 0; digit 0 never blanked by this rule.
REQ-026 SHALL, without LEADING_ZERO_BLANK_EN, blank only per REQ-018; zeros are displayed.

Verification (SCAN_DIV=4)
REQ-027 SHALL cover reset: hold rst_n=0 -> dig_en=0001, bcd=0, frame_done=0; release -> index advances every 4 cycles, frame_done pulses every 16.
REQ-028 SHALL cover load/display: load din=16'h1234 mid-frame -> display unchanged until next frame_done, then bcd sequence 4,3,2,1 with dig_en 0001,0010,0100,1000.
REQ-029 SHALL cover simultaneous load at boundary: load 16'h5678 at boundary with pending 16'h1234 -> next frame shows 1234, following frame shows 5678.
REQ-030 SHALL cover invalid digit: din=16'h00A9 -> digit 1 slot blank=1, dig_en=0000, bcd=4'hA; digit 0 shows 9.
REQ-031 SHALL cover leading zeros: din=16'h0050 -> with LEADING_ZERO_BLANK_EN digits 3,2 blanked, digits 1,0 show 5,0; without the macro all four lit.
REQ-032 SHALL cover reset mid-frame: assert rst_n=0 at index=2 after load 16'h9999 -> outputs return to REQ-021 values and 9999 never displayed.
